// File: rtl/mem_pkg.sv
// Shared types and defaults for the line-organised burst memory unit.
package mem_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRd,
    StWr
  } state_e;

  localparam int unsigned DefDw    = 16;
  localparam int unsigned DefWpl   = 4;
  localparam int unsigned DefLines = 128;

  function automatic int unsigned offset_width(int unsigned wpl);
    return $clog2(wpl);
  endfunction

  localparam int unsigned DefOw = offset_width(DefWpl);

endpackage

// File: rtl/mem_line_store.sv
// LINES x WPL x DW register array: one synchronous write port, one combinational read port.
module mem_line_store
  import mem_pkg::*;
#(
  parameter int unsigned DW    = DefDw,
  parameter int unsigned WPL   = DefWpl,
  parameter int unsigned LINES = DefLines,
  parameter int unsigned OW    = offset_width(WPL),
  parameter int unsigned LW    = $clog2(LINES)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [LW-1:0] wr_line,
  input  logic [OW-1:0] wr_off,
  input  logic [DW-1:0] wr_data,
  input  logic [LW-1:0] rd_line,
  input  logic [OW-1:0] rd_off,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem_q [LINES][WPL];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned l = 0; l < LINES; l++) begin
        for (int unsigned w = 0; w < WPL; w++) begin
          mem_q[l][w] <= '0;
        end
      end
    end else if (we) begin
      mem_q[wr_line][wr_off] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_line][rd_off];

endmodule

// File: rtl/mem_burst_unit.sv
// Request/ready front end over the line store: single-word or line-wrapping burst transfers
// with a registered read data path.
module mem_burst_unit
  import mem_pkg::*;
#(
  parameter int unsigned DW    = DefDw,
  parameter int unsigned WPL   = DefWpl,
  parameter int unsigned LINES = DefLines,
  parameter int unsigned AW    = $clog2(LINES * WPL)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic          req_burst,
  input  logic [AW-1:0] req_addr,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [DW-1:0] wr_data,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [DW-1:0] rd_data,
  output logic          rd_last
);

  localparam int unsigned OW = offset_width(WPL);
  localparam int unsigned LW = AW - OW;

  state_e        state_q;
  logic [LW-1:0] line_q;
  logic [OW-1:0] off_q;
  logic [OW-1:0] beats_q;
  logic [DW-1:0] rd_data_q;
  logic          rd_valid_q;
  logic          rd_last_q;

  logic [LW-1:0] req_line;
  logic [OW-1:0] req_off;
  logic [OW-1:0] off_next;
  logic [LW-1:0] rd_line;
  logic [OW-1:0] rd_off;
  logic [DW-1:0] store_rdata;
  logic          wr_hs;

  assign req_line = req_addr[AW-1:OW];
  assign req_off  = req_addr[OW-1:0];
  // Offset wraps within the line because OW bits cover exactly WPL words.
  assign off_next = off_q + OW'(1);
  assign wr_hs    = (state_q == StWr) && wr_valid;

  // Look up the requested word while idle, otherwise prefetch the next beat of the burst.
  always_comb begin
    rd_line = line_q;
    rd_off  = off_next;
    if (state_q == StIdle) begin
      rd_line = req_line;
      rd_off  = req_off;
    end
  end

  mem_line_store #(
    .DW   (DW),
    .WPL  (WPL),
    .LINES(LINES),
    .OW   (OW),
    .LW   (LW)
  ) u_store (
    .clk    (clk),
    .rst    (rst),
    .we     (wr_hs),
    .wr_line(line_q),
    .wr_off (off_q),
    .wr_data(wr_data),
    .rd_line(rd_line),
    .rd_off (rd_off),
    .rd_data(store_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      line_q     <= '0;
      off_q      <= '0;
      beats_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            line_q  <= req_line;
            off_q   <= req_off;
            beats_q <= req_burst ? OW'(WPL - 1) : '0;
            if (req_we) begin
              state_q <= StWr;
            end else begin
              state_q    <= StRd;
              rd_data_q  <= store_rdata;
              rd_valid_q <= 1'b1;
              rd_last_q  <= !req_burst;
            end
          end
        end
        StRd: begin
          if (rd_valid_q && rd_ready) begin
            if (beats_q == '0) begin
              state_q    <= StIdle;
              rd_valid_q <= 1'b0;
              rd_last_q  <= 1'b0;
            end else begin
              off_q     <= off_next;
              beats_q   <= beats_q - OW'(1);
              rd_data_q <= store_rdata;
              rd_last_q <= (beats_q == OW'(1));
            end
          end
        end
        StWr: begin
          if (wr_valid) begin
            if (beats_q == '0) begin
              state_q <= StIdle;
            end else begin
              off_q   <= off_next;
              beats_q <= beats_q - OW'(1);
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign req_ready = (state_q == StIdle);
  assign wr_ready  = (state_q == StWr);
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
  assign rd_last   = rd_last_q;

endmodule

// File: tb/tb_mem_burst_unit.sv
// Directed bench for mem_burst_unit: expected read beats are queued at issue time and checked
// by an independent monitor whenever the unit presents a read beat.
module tb_mem_burst_unit;

  localparam int unsigned DW    = 16;
  localparam int unsigned WPL   = 4;
  localparam int unsigned LINES = 128;
  localparam int unsigned AW    = 9;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic          req_burst;
  logic [AW-1:0] req_addr;
  logic          wr_valid;
  logic          wr_ready;
  logic [DW-1:0] wr_data;
  logic          rd_valid;
  logic          rd_ready;
  logic [DW-1:0] rd_data;
  logic          rd_last;

  int n_checks = 0;
  int n_fail   = 0;

  // Each entry is {last, data}.
  logic [DW:0] exp_q[$];

  mem_burst_unit #(
    .DW   (DW),
    .WPL  (WPL),
    .LINES(LINES)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we   (req_we),
    .req_burst(req_burst),
    .req_addr (req_addr),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_data  (wr_data),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .rd_data  (rd_data),
    .rd_last  (rd_last)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: a beat with rd_ready high completes at the next rising edge; with rd_ready low the
  // same expected beat must remain on the port.
  always @(negedge clk) begin
    if (!rst && rd_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected read beat: got data 0x%0h, expected no beat", rd_data);
      end else begin
        check("rd_data", 32'(rd_data), 32'(exp_q[0][DW-1:0]));
        check("rd_last", 32'(rd_last), 32'(exp_q[0][DW]));
        if (rd_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic we, input logic burst, input logic [AW-1:0] addr);
    int n = 0;
    req_valid = 1'b1;
    req_we    = we;
    req_burst = burst;
    req_addr  = addr;
    while (!req_ready && n < 50) begin
      cyc();
      n++;
    end
    check("req_ready before accept", 32'(req_ready), 32'd1);
    cyc();
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      cyc();
      n++;
    end
    check("read drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic rd1(input logic [AW-1:0] addr, input logic [DW-1:0] val);
    exp_q.push_back({1'b1, val});
    issue(1'b0, 1'b0, addr);
    check("rd_valid latency", 32'(rd_valid), 32'd1);
    drain();
  endtask

  // Beat i of a burst is vals[16*(3-i) +: 16], i.e. listed left to right.
  task automatic rdb(input logic [AW-1:0] addr, input logic [63:0] vals);
    for (int i = 0; i < 4; i++) exp_q.push_back({i == 3, vals[16*(3-i) +: 16]});
    issue(1'b0, 1'b1, addr);
    check("rd_valid latency", 32'(rd_valid), 32'd1);
    drain();
  endtask

  task automatic wrb(input logic [AW-1:0] addr, input logic burst, input logic [63:0] vals);
    int nb;
    nb = burst ? 4 : 1;
    issue(1'b1, burst, addr);
    for (int i = 0; i < nb; i++) begin
      wr_valid = 1'b1;
      wr_data  = vals[16*(3-i) +: 16];
      check("wr_ready in WR", 32'(wr_ready), 32'd1);
      cyc();
    end
    wr_valid = 1'b0;
    check("wr_ready after write", 32'(wr_ready), 32'd0);
    check("req_ready after write", 32'(req_ready), 32'd1);
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_burst = 1'b0;
    req_addr  = '0;
    wr_valid  = 1'b0;
    wr_data   = '0;
    rd_ready  = 1'b1;
    #2;
    check("reset req_ready", 32'(req_ready), 32'd1);
    check("reset wr_ready", 32'(wr_ready), 32'd0);
    check("reset rd_valid", 32'(rd_valid), 32'd0);
    check("reset rd_last", 32'(rd_last), 32'd0);
    check("reset rd_data", 32'(rd_data), 32'd0);
    cyc();
    cyc();
    rst = 1'b0;

    // Single read after reset, then single write / readback with untouched neighbours.
    rd1(9'h1A5, 16'h0000);
    wrb(9'h1A5, 1'b0, {16'hBEEF, 48'h0});
    rd1(9'h1A5, 16'hBEEF);
    rd1(9'h1A4, 16'h0000);
    rd1(9'h1A6, 16'h0000);

    // Burst write from offset 2 wraps to 0,1; read back critical-word-first from both ends.
    wrb(9'h012, 1'b1, 64'h1111_2222_3333_4444);
    rdb(9'h010, 64'h3333_4444_1111_2222);
    rd1(9'h013, 16'h2222);

    // Burst read with consumer stalls on beats 2 and 3.
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back({i == 3, (i == 0) ? 16'h3333 : (i == 1) ? 16'h4444 :
                               (i == 2) ? 16'h1111 : 16'h2222});
    end
    issue(1'b0, 1'b1, 9'h010);
    check("rd_valid latency", 32'(rd_valid), 32'd1);
    cyc();
    for (int b = 0; b < 2; b++) begin
      rd_ready = 1'b0;
      repeat (3) begin
        check("req_ready during stall", 32'(req_ready), 32'd0);
        cyc();
      end
      rd_ready = 1'b1;
      cyc();
    end
    check("req_ready before last beat", 32'(req_ready), 32'd0);
    drain();
    check("req_ready after burst read", 32'(req_ready), 32'd1);

    // Burst write with 2-cycle gaps; a read request held pending must wait for IDLE.
    issue(1'b1, 1'b1, 9'h040);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_burst = 1'b0;
    req_addr  = 9'h042;
    exp_q.push_back({1'b1, 16'hC2C2});
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1'b1;
      wr_data  = (i == 0) ? 16'hA0A0 : (i == 1) ? 16'hB1B1 : (i == 2) ? 16'hC2C2 : 16'hD3D3;
      check("req_ready during write", 32'(req_ready), 32'd0);
      cyc();
      wr_valid = 1'b0;
      wr_data  = 16'hDEAD;
      if (i < 3) begin
        repeat (2) begin
          check("wr_ready in gap", 32'(wr_ready), 32'd1);
          check("req_ready in gap", 32'(req_ready), 32'd0);
          cyc();
        end
      end
    end
    check("pending req_ready at idle", 32'(req_ready), 32'd1);
    cyc();
    req_valid = 1'b0;
    check("pending read accepted", 32'(rd_valid), 32'd1);
    drain();
    rdb(9'h040, 64'hA0A0_B1B1_C2C2_D3D3);

    // Reset after two of four burst-write beats.
    issue(1'b1, 1'b1, 9'h080);
    for (int i = 0; i < 2; i++) begin
      wr_valid = 1'b1;
      wr_data  = (i == 0) ? 16'h5555 : 16'h6666;
      cyc();
    end
    wr_valid = 1'b0;
    rst      = 1'b1;
    #1;
    check("mid reset req_ready", 32'(req_ready), 32'd1);
    check("mid reset wr_ready", 32'(wr_ready), 32'd0);
    check("mid reset rd_valid", 32'(rd_valid), 32'd0);
    check("mid reset rd_last", 32'(rd_last), 32'd0);
    check("mid reset rd_data", 32'(rd_data), 32'd0);
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) exp_q.push_back({i == 3, 16'h0000});
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_burst = 1'b1;
    req_addr  = 9'h080;
    check("req_ready after release", 32'(req_ready), 32'd1);
    cyc();
    req_valid = 1'b0;
    check("accept after release", 32'(rd_valid), 32'd1);
    drain();
    rd1(9'h1A5, 16'h0000);
    rdb(9'h010, 64'h0);
    rdb(9'h040, 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
